star_scroll_ctrl: RTL
=====================

// Module: star_scroll_ctrl
// PURPOSE
//  Frame-level scheduler and configurator for the starfield layer. Converts fsync
//  into per-frame scroll strobes, sequences warp-speed ramps (up/hold/down),
//  freezes the field while paused, and runs a reseed handshake with the star
//  generator at power-up and on every GAME_OVER->TITLE restart.
//  Sits between the game-state FSM and the star background layer.
// PARAMETERS
//  WARP_MULT    4    peak speed multiplier during warp (legal 2..7)
//  RAMP_FRAMES  8    frames per +/-1 multiplier step (>=1)
//  HOLD_FRAMES  120  frames held at WARP_MULT (>=1)
//  FCNT_W       16   width of frame_cnt
// PORTS
//  pixel_clk    in   1       pixel clock, all logic on rising edge
//  rst          in   1       synchronous, active-high reset
//  fsync        in   1       one-cycle pulse per frame
//  game_state   in   2       0=TITLE 1=PLAYING 2=PAUSED 3=GAME_OVER
//  warp_req     in   1       one-cycle warp request
//  reseed_ack   in   1       star generator finished reseeding
//  scroll_en    out  1       one-cycle strobe: advance stars this frame
//  speed_mult   out  3       multiplier applied to per-star speed (1..WARP_MULT)
//  reseed_req   out  1       level request to regenerate star positions
//  warp_active  out  1       high in WARP_UP/WARP_HOLD/WARP_DOWN
//  frame_cnt    out  FCNT_W  count of scrolled frames, wraps
// BEHAVIOUR
//  Reset: state=RESEED, reseed_req=1, scroll_en=0, speed_mult=1, warp_active=0,
//   frame_cnt=0, ramp/hold counters=0, prev_state=0.
//  States: RESEED, RUN, WARP_UP, WARP_HOLD, WARP_DOWN, FROZEN.
//  RESEED: reseed_req=1; fsync ignored (no scroll_en, no frame_cnt++). When
//   reseed_ack=1: next cycle reseed_req=0 and state->RUN, or FROZEN (ret=RUN) if
//   game_state==PAUSED. reseed_ack outside RESEED is ignored.
//  scroll_en: registered pulse 1 cycle after an fsync seen in RUN/WARP_*; same
//   edge increments frame_cnt (mod 2^FCNT_W) and applies ramp steps, so
//   speed_mult is already updated when scroll_en is high.
//  RUN: warp_req with game_state==PLAYING -> WARP_UP, ramp_cnt=0, warp_active=1.
//   warp_req in any other state/game_state is dropped (not queued).
//  WARP_UP: each fsync ramp_cnt++; at ramp_cnt==RAMP_FRAMES: speed_mult++,
//   ramp_cnt=0; when speed_mult reaches WARP_MULT -> WARP_HOLD, hold_cnt=0.
//  WARP_HOLD: each fsync hold_cnt++; at HOLD_FRAMES -> WARP_DOWN, ramp_cnt=0.
//  WARP_DOWN: mirror of WARP_UP, decrementing; at speed_mult==1 -> RUN,
//   warp_active=0.
//  FROZEN: entered from RUN/WARP_* when game_state==PAUSED; saves return state;
//   no scroll_en, counters and speed_mult hold. Leaves to saved state when
//   game_state!=PAUSED; warp_active stays at saved value throughout.
//  Restart: prev_state==3 && game_state==0 (registered compare) forces RESEED
//   from any state: reseed_req=1, speed_mult=1, warp_active=0, counters cleared.
//  Priority per cycle: rst > restart > pause entry/exit > fsync processing >
//   warp_req. fsync coincident with a transition is processed under the old
//   state only if that state is not left by restart/pause in the same cycle.
//  Arithmetic: speed_mult saturates in [1,WARP_MULT]; counters sized
//   $clog2(max+1); frame_cnt wraps silently.
// TESTING
//  T1 rst 4 cyc, ack 5 cyc later -> reseed_req 1 until ack, 0 next cyc; 3 fsyncs
//     -> 3 scroll_en pulses, each 1 cyc after fsync, mult=1, frame_cnt=3.
//  T2 RAMP=2,HOLD=3,WARP_MULT=4, PLAYING, warp_req -> mult 2,3,4 after fsync
//     2,4,6; WARP_DOWN at fsync 9; mult 3,2,1 at 11,13,15; warp_active 0 at 15.
//  T3 game_state=PAUSED at fsync 5 of T2 -> no scroll_en, mult=3 holds over 10
//     fsyncs; PLAYING again -> ramp resumes from ramp_cnt value saved at pause.
//  T4 GAME_OVER->TITLE during WARP_HOLD -> reseed_req=1, mult=1, warp_active=0,
//     fsyncs ignored until ack; reseed_ack pulsed in RUN -> no effect.
//  T5 warp_req in PAUSED, WARP_UP and RESEED -> dropped, no state change;
//     FCNT_W=4, 17 fsyncs in RUN -> frame_cnt=1.

Source files
------------

// File: rtl/star_scroll_ctrl.sv
// Frame-level scheduler for the starfield layer: scroll strobes, warp-speed ramps,
// pause freezing and the reseed handshake with the star generator.
`timescale 1ns/1ps
module star_scroll_ctrl #(
  parameter int WARP_MULT   = 4,
  parameter int RAMP_FRAMES = 8,
  parameter int HOLD_FRAMES = 120,
  parameter int FCNT_W      = 16
) (
  input  logic              pixel_clk,
  input  logic              rst,
  input  logic              fsync,
  input  logic [1:0]        game_state,
  input  logic              warp_req,
  input  logic              reseed_ack,
  output logic              scroll_en,
  output logic [2:0]        speed_mult,
  output logic              reseed_req,
  output logic              warp_active,
  output logic [FCNT_W-1:0] frame_cnt
);

  localparam int RAMP_W = $clog2(RAMP_FRAMES + 1);
  localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);

  localparam logic [1:0] GS_TITLE   = 2'd0;
  localparam logic [1:0] GS_PLAYING = 2'd1;
  localparam logic [1:0] GS_PAUSED  = 2'd2;
  localparam logic [1:0] GS_OVER    = 2'd3;

  localparam logic [2:0]        MULT_MAX  = 3'(WARP_MULT);
  localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_FRAMES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES);

  typedef enum logic [2:0] {
    S_RESEED, S_RUN, S_WARP_UP, S_WARP_HOLD, S_WARP_DOWN, S_FROZEN
  } state_t;

  state_t              state_q, state_d, ret_q, ret_d;
  logic [1:0]          prev_gs_q;
  logic [RAMP_W-1:0]   ramp_q, ramp_d, ramp_inc;
  logic [HOLD_W-1:0]   hold_q, hold_d, hold_inc;
  logic [2:0]          mult_q, mult_d;
  logic                warp_q, warp_d;
  logic                scroll_q, scroll_d;
  logic                reseed_q;
  logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
  logic                restart, paused;

  assign ramp_inc = ramp_q + RAMP_W'(1);
  assign hold_inc = hold_q + HOLD_W'(1);
  assign restart  = (prev_gs_q == GS_OVER) && (game_state == GS_TITLE);
  assign paused   = (game_state == GS_PAUSED);

  always_comb begin
    state_d  = state_q;
    ret_d    = ret_q;
    ramp_d   = ramp_q;
    hold_d   = hold_q;
    mult_d   = mult_q;
    warp_d   = warp_q;
    fcnt_d   = fcnt_q;
    scroll_d = 1'b0;
    if (restart) begin
      state_d = S_RESEED;
      mult_d  = 3'd1;
      warp_d  = 1'b0;
      ramp_d  = '0;
      hold_d  = '0;
    end else begin
      case (state_q)
        S_RESEED: begin
          if (reseed_ack) begin
            state_d = paused ? S_FROZEN : S_RUN;
            ret_d   = S_RUN;
          end
        end
        S_FROZEN: begin
          if (!paused) state_d = ret_q;
        end
        default: begin
          if (paused) begin
            state_d = S_FROZEN;
            ret_d   = state_q;
          end else begin
            if (fsync) begin
              scroll_d = 1'b1;
              fcnt_d   = fcnt_q + FCNT_W'(1);
              case (state_q)
                S_WARP_UP: begin
                  if (ramp_inc == RAMP_LAST) begin
                    ramp_d = '0;
                    mult_d = (mult_q < MULT_MAX) ? mult_q + 3'd1 : mult_q;
                    if (mult_d >= MULT_MAX) begin
                      state_d = S_WARP_HOLD;
                      hold_d  = '0;
                    end
                  end else begin
                    ramp_d = ramp_inc;
                  end
                end
                S_WARP_HOLD: begin
                  hold_d = hold_inc;
                  if (hold_inc == HOLD_LAST) begin
                    state_d = S_WARP_DOWN;
                    ramp_d  = '0;
                  end
                end
                S_WARP_DOWN: begin
                  if (ramp_inc == RAMP_LAST) begin
                    ramp_d = '0;
                    mult_d = (mult_q > 3'd1) ? mult_q - 3'd1 : mult_q;
                    if (mult_d <= 3'd1) begin
                      state_d = S_RUN;
                      warp_d  = 1'b0;
                    end
                  end else begin
                    ramp_d = ramp_inc;
                  end
                end
                default: ;
              endcase
            end
            // Warp requests only start a ramp from plain RUN; elsewhere they are dropped.
            if (state_q == S_RUN && warp_req && game_state == GS_PLAYING) begin
              state_d = S_WARP_UP;
              ramp_d  = '0;
              warp_d  = 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      state_q   <= S_RESEED;
      ret_q     <= S_RUN;
      prev_gs_q <= GS_TITLE;
      ramp_q    <= '0;
      hold_q    <= '0;
      mult_q    <= 3'd1;
      warp_q    <= 1'b0;
      scroll_q  <= 1'b0;
      reseed_q  <= 1'b1;
      fcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      ret_q     <= ret_d;
      prev_gs_q <= game_state;
      ramp_q    <= ramp_d;
      hold_q    <= hold_d;
      mult_q    <= mult_d;
      warp_q    <= warp_d;
      scroll_q  <= scroll_d;
      reseed_q  <= (state_d == S_RESEED);
      fcnt_q    <= fcnt_d;
    end
  end

  assign scroll_en   = scroll_q;
  assign speed_mult  = mult_q;
  assign reseed_req  = reseed_q;
  assign warp_active = warp_q;
  assign frame_cnt   = fcnt_q;

endmodule
